robot_map_memo: RTL and testbench
=================================

# robot_map_memo

Parametrised successor of the robot map memory: an ROWS x COLS grid of 2-bit cells with a robot position/orientation register, a command FSM and a sensor pipeline reading a single-port synchronous RAM. Accepts one movement command (avancar / girar / remover) at a time, with busy-based flow control. Exposes head/left/under/barrier sensors, step and bump counters, and an error pulse to the navigation controller. A map-load write port allows the map to be filled at run time.

## Interface
- ROWS, 10, grid rows
- COLS, 20, grid columns
- START_ROW, 0, row after reset
- START_COL, 0, column after reset
- START_ORI, 1, orientation after reset (0 N, 1 E, 2 S, 3 W)
- Derived: RW=$clog2(ROWS), CW=$clog2(COLS), AW=$clog2(ROWS*COLS); cell address = row*COLS+col
- clock  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-low; clears all registers except RAM contents
- avancar  in  1  move one cell forward
- girar  in  1  rotate 90° clockwise
- remover  in  1  clear barrier in cell ahead
- map_we  in  1  map write strobe
- map_addr  in  AW  map write address
- map_wdata  in  2  cell code: 00 free, 01 wall, 10 barrier, 11 marker
- busy  out  1  FSM not idle; commands/writes ignored
- robo_row  out  RW  current row
- robo_col  out  CW  current column
- robo_orientacao  out  2  current orientation
- head_out  out  1  cell ahead blocked (wall, barrier or off-grid)
- left_out  out  1  cell to the left blocked (wall, barrier or off-grid)
- under_out  out  1  current cell is marker (11)
- barrier_out  out  1  cell ahead is barrier (10)
- step_count  out  16  successful advances, saturating at 0xFFFF
- bump_count  out  8  blocked advances, saturating at 0xFF
- err_out  out  1  one-cycle pulse: remover with no barrier ahead

## Operation
- States: IDLE, EXEC, SENSE_H, SENSE_L, SENSE_U, SENSE_D.
- IDLE (busy=0): samples commands each edge. Priority remover > avancar > girar; lower-priority commands asserted in the same cycle are dropped. Accepted command -> EXEC.
- map_we in IDLE with no command asserted: writes RAM, -> SENSE_H. map_we while busy or with a command in the same cycle: ignored.
- EXEC: avancar with head_out=0 moves one cell in orientation direction, step_count+1; with head_out=1 no move, bump_count+1. girar: ori=(ori+1) mod 4. remover: barrier_out=1 writes 00 to cell ahead; otherwise no write, err_out=1 during this cycle. Always -> SENSE_H.
- Sense sequence: SENSE_H addresses cell ahead, SENSE_L addresses left cell (orientation ori-1), SENSE_U addresses current cell; read data, one cycle later, is captured into shadow registers; SENSE_D captures last read -> IDLE.
- Off-grid neighbour (row/col outside 0..ROWS-1 / 0..COLS-1): no RAM read, shadow forced to wall (01).
- Sensor outputs update together from shadows on the edge entering IDLE; they hold previous values while busy.
- Commands use the sensor values currently presented, so decisions are consistent with the last sense.

## Timing
- Reset values: row=START_ROW, col=START_COL, ori=START_ORI, all sensors 0, step_count 0, bump_count 0, err_out 0, busy 1, state SENSE_H.
- After reset release: busy=1 for 4 cycles, then IDLE with valid sensors.
- Command accepted at edge k: busy=1 from k for 5 cycles (EXEC + 4 sense); position/orientation/counters change at edge k+1; RAM write (remover) at edge k+1; sensors valid and busy=0 at edge k+5.
- Map write accepted at edge k: busy=0 again after 4 cycles.
- Reset mid-sequence: immediate abort to reset values, pending EXEC write lost, RAM unchanged; sensing restarts.
- Counters saturate; no wrap.

## Test plan
- Free map, reset release -> busy high 4 cycles, then (0,0) ori 1, head_out=0, left_out=1 (north off-grid), step_count 0.
- avancar pulse from (0,0) E -> busy exactly 5 cycles, robo_col=1, step_count=1.
- girar x3 from E -> ori 2,3,0; at row 0 facing N head_out=1; avancar -> position unchanged, bump_count=1.
- map_wdata=10 at address 2, robot (0,1) E -> barrier_out=1, head_out=1; remover -> barrier_out=0, head_out=0; remover again -> err_out one-cycle pulse, RAM unchanged.
- avancar+girar same cycle -> only advance, ori unchanged; address 3 = 11, advance onto (0,3) -> under_out=1.
- Assert reset during SENSE_L -> outputs return to reset values asynchronously; sensing restarts and busy=0 4 cycles after release.

Source files
------------

// File: rtl/robot_map_memo.sv
// Robot map memory: ROWS x COLS grid of 2-bit cells, robot pose register,
// a one-command-at-a-time FSM and a four-step sensor sweep over a single-port RAM.
module robot_map_memo #(
    parameter int ROWS      = 10,
    parameter int COLS      = 20,
    parameter int START_ROW = 0,
    parameter int START_COL = 0,
    parameter int START_ORI = 1,
    localparam int RW = $clog2(ROWS),
    localparam int CW = $clog2(COLS),
    localparam int AW = $clog2(ROWS*COLS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          avancar,
    input  logic          girar,
    input  logic          remover,
    input  logic          map_we,
    input  logic [AW-1:0] map_addr,
    input  logic [1:0]    map_wdata,
    output logic          busy,
    output logic [RW-1:0] robo_row,
    output logic [CW-1:0] robo_col,
    output logic [1:0]    robo_orientacao,
    output logic          head_out,
    output logic          left_out,
    output logic          under_out,
    output logic          barrier_out,
    output logic [15:0]   step_count,
    output logic [7:0]    bump_count,
    output logic          err_out
);

    typedef enum logic [2:0] {
        S_IDLE, S_EXEC, S_SENSE_H, S_SENSE_L, S_SENSE_U, S_SENSE_D
    } state_t;

    typedef enum logic [1:0] {CMD_ADV, CMD_ROT, CMD_REM} cmd_t;

    localparam logic [1:0] CELL_FREE    = 2'b00;
    localparam logic [1:0] CELL_WALL    = 2'b01;
    localparam logic [1:0] CELL_BARRIER = 2'b10;
    localparam logic [1:0] CELL_MARKER  = 2'b11;

    // Returns {off_grid, row, col} of the neighbour in direction dir.
    function automatic logic [RW+CW:0] neighbour(input logic [RW-1:0] r,
                                                 input logic [CW-1:0] c,
                                                 input logic [1:0]    dir);
        logic          off;
        logic [RW-1:0] nr;
        logic [CW-1:0] nc;
        off = 1'b0;
        nr  = r;
        nc  = c;
        case (dir)
            2'd0:    if (r == '0) off = 1'b1; else nr = r - 1'b1;
            2'd1:    if (c == CW'(COLS-1)) off = 1'b1; else nc = c + 1'b1;
            2'd2:    if (r == RW'(ROWS-1)) off = 1'b1; else nr = r + 1'b1;
            default: if (c == '0) off = 1'b1; else nc = c - 1'b1;
        endcase
        return {off, nr, nc};
    endfunction

    function automatic logic [AW-1:0] cell_addr(input logic [RW-1:0] r,
                                                input logic [CW-1:0] c);
        return AW'(int'(r) * COLS + int'(c));
    endfunction

    function automatic logic blocked(input logic [1:0] code);
        return (code == CELL_WALL) || (code == CELL_BARRIER);
    endfunction

    state_t        state_q, state_d;
    cmd_t          cmd_q, cmd_d;
    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic [1:0]    ori_q, ori_d;
    logic [1:0]    shadow_h_q, shadow_h_d;
    logic [1:0]    shadow_l_q, shadow_l_d;
    logic          rd_off_q, rd_off_d;
    logic          head_q, head_d;
    logic          left_q, left_d;
    logic          under_q, under_d;
    logic          barrier_q, barrier_d;
    logic [15:0]   step_q, step_d;
    logic [7:0]    bump_q, bump_d;

    logic          ahead_off, left_off;
    logic [RW-1:0] ahead_row, left_row;
    logic [CW-1:0] ahead_col, left_col;

    logic          ram_we, ram_re;
    logic [AW-1:0] ram_addr;
    logic [1:0]    ram_wdata;
    logic [1:0]    ram_rdata_q;
    logic [1:0]    mem_q [ROWS*COLS];

    always_comb begin
        {ahead_off, ahead_row, ahead_col} = neighbour(row_q, col_q, ori_q);
        {left_off, left_row, left_col}    = neighbour(row_q, col_q, ori_q - 2'd1);
    end

    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        row_d      = row_q;
        col_d      = col_q;
        ori_d      = ori_q;
        shadow_h_d = shadow_h_q;
        shadow_l_d = shadow_l_q;
        rd_off_d   = rd_off_q;
        head_d     = head_q;
        left_d     = left_q;
        under_d    = under_q;
        barrier_d  = barrier_q;
        step_d     = step_q;
        bump_d     = bump_q;
        ram_we     = 1'b0;
        ram_re     = 1'b0;
        ram_addr   = cell_addr(row_q, col_q);
        ram_wdata  = map_wdata;

        case (state_q)
            S_IDLE: begin
                if (remover || avancar || girar) begin
                    if (remover)      cmd_d = CMD_REM;
                    else if (avancar) cmd_d = CMD_ADV;
                    else              cmd_d = CMD_ROT;
                    state_d = S_EXEC;
                end else if (map_we) begin
                    // Out-of-range addresses are dropped but still trigger a resense.
                    ram_we   = (int'(map_addr) < ROWS*COLS);
                    ram_addr = map_addr;
                    state_d  = S_SENSE_H;
                end
            end
            S_EXEC: begin
                state_d = S_SENSE_H;
                case (cmd_q)
                    CMD_ADV: begin
                        if (!head_q && !ahead_off) begin
                            row_d = ahead_row;
                            col_d = ahead_col;
                            if (step_q != 16'hFFFF) step_d = step_q + 16'd1;
                        end else if (bump_q != 8'hFF) begin
                            bump_d = bump_q + 8'd1;
                        end
                    end
                    CMD_ROT: ori_d = ori_q + 2'd1;
                    default: begin
                        if (barrier_q && !ahead_off) begin
                            ram_we    = 1'b1;
                            ram_addr  = cell_addr(ahead_row, ahead_col);
                            ram_wdata = CELL_FREE;
                        end
                    end
                endcase
            end
            // Each read lands one cycle later and is captured in the next state.
            S_SENSE_H: begin
                ram_addr = cell_addr(ahead_row, ahead_col);
                ram_re   = !ahead_off;
                rd_off_d = ahead_off;
                state_d  = S_SENSE_L;
            end
            S_SENSE_L: begin
                shadow_h_d = rd_off_q ? CELL_WALL : ram_rdata_q;
                ram_addr   = cell_addr(left_row, left_col);
                ram_re     = !left_off;
                rd_off_d   = left_off;
                state_d    = S_SENSE_U;
            end
            S_SENSE_U: begin
                shadow_l_d = rd_off_q ? CELL_WALL : ram_rdata_q;
                ram_re     = 1'b1;
                rd_off_d   = 1'b0;
                state_d    = S_SENSE_D;
            end
            S_SENSE_D: begin
                head_d    = blocked(shadow_h_q);
                left_d    = blocked(shadow_l_q);
                barrier_d = (shadow_h_q == CELL_BARRIER);
                under_d   = (ram_rdata_q == CELL_MARKER);
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_SENSE_H;
            cmd_q      <= CMD_ADV;
            row_q      <= RW'(START_ROW);
            col_q      <= CW'(START_COL);
            ori_q      <= 2'(START_ORI);
            shadow_h_q <= CELL_FREE;
            shadow_l_q <= CELL_FREE;
            rd_off_q   <= 1'b0;
            head_q     <= 1'b0;
            left_q     <= 1'b0;
            under_q    <= 1'b0;
            barrier_q  <= 1'b0;
            step_q     <= 16'd0;
            bump_q     <= 8'd0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            row_q      <= row_d;
            col_q      <= col_d;
            ori_q      <= ori_d;
            shadow_h_q <= shadow_h_d;
            shadow_l_q <= shadow_l_d;
            rd_off_q   <= rd_off_d;
            head_q     <= head_d;
            left_q     <= left_d;
            under_q    <= under_d;
            barrier_q  <= barrier_d;
            step_q     <= step_d;
            bump_q     <= bump_d;
        end
    end

    // Map storage is never reset; only the control around it is.
    always_ff @(posedge clk) begin
        if (ram_we) mem_q[ram_addr] <= ram_wdata;
        if (ram_re) ram_rdata_q <= mem_q[ram_addr];
    end

    assign busy            = (state_q != S_IDLE);
    assign robo_row        = row_q;
    assign robo_col        = col_q;
    assign robo_orientacao = ori_q;
    assign head_out        = head_q;
    assign left_out        = left_q;
    assign under_out       = under_q;
    assign barrier_out     = barrier_q;
    assign step_count      = step_q;
    assign bump_count      = bump_q;
    assign err_out         = (state_q == S_EXEC) && (cmd_q == CMD_REM) && !barrier_q;

endmodule

// File: tb/tb_robot_map_memo.sv
// Directed bench for robot_map_memo: reset, moves, rotation, barrier removal,
// marker sensing and a mid-sweep asynchronous reset.
module tb_robot_map_memo;

    localparam int ROWS = 10;
    localparam int COLS = 20;
    localparam int AW   = $clog2(ROWS*COLS);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          avancar, girar, remover, map_we;
    logic [AW-1:0] map_addr;
    logic [1:0]    map_wdata;
    logic          busy, head_out, left_out, under_out, barrier_out, err_out;
    logic [3:0]    robo_row;
    logic [4:0]    robo_col;
    logic [1:0]    robo_orientacao;
    logic [15:0]   step_count;
    logic [7:0]    bump_count;

    int pass_cnt  = 0;
    int total_cnt = 0;

    robot_map_memo #(.ROWS(ROWS), .COLS(COLS)) dut (
        .clk(clk), .rst_n(rst_n),
        .avancar(avancar), .girar(girar), .remover(remover),
        .map_we(map_we), .map_addr(map_addr), .map_wdata(map_wdata),
        .busy(busy), .robo_row(robo_row), .robo_col(robo_col),
        .robo_orientacao(robo_orientacao),
        .head_out(head_out), .left_out(left_out), .under_out(under_out),
        .barrier_out(barrier_out), .step_count(step_count),
        .bump_count(bump_count), .err_out(err_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 40) begin
            tick();
            n++;
        end
        if (busy) chk(tag, busy, 0);
    endtask

    // Pulse a command for one edge; report busy length, err in EXEC and one cycle later.
    task automatic run_cmd(input logic a, input logic g, input logic r,
                           output int n, output logic err_exec, output logic err_next);
        avancar = a; girar = g; remover = r;
        tick();
        avancar = 1'b0; girar = 1'b0; remover = 1'b0;
        err_exec = err_out;
        err_next = 1'b0;
        n = 0;
        while (busy && n < 40) begin
            tick();
            n++;
            if (n == 1) err_next = err_out;
        end
    endtask

    task automatic map_write(input int addr, input logic [1:0] code, output int n);
        map_we = 1'b1; map_addr = AW'(addr); map_wdata = code;
        tick();
        map_we = 1'b0;
        n = 0;
        while (busy && n < 40) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int   n;
        logic e1, e2;

        rst_n = 1'b0; avancar = 1'b0; girar = 1'b0; remover = 1'b0;
        map_we = 1'b0; map_addr = '0; map_wdata = 2'b00;
        #12;
        chk("rst_busy", busy, 1);
        chk("rst_row", robo_row, 0);
        chk("rst_col", robo_col, 0);
        chk("rst_ori", robo_orientacao, 1);
        chk("rst_head", head_out, 0);
        chk("rst_step", step_count, 0);
        chk("rst_bump", bump_count, 0);
        chk("rst_err", err_out, 0);
        tick();
        rst_n = 1'b1;
        wait_idle("init_idle");

        for (int a = 0; a < ROWS*COLS; a++) begin
            map_write(a, 2'b00, n);
            if (n >= 40) chk("fill_timeout", n, 4);
        end

        // Fresh reset over the free map
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n = 0;
        while (busy && n < 40) begin
            tick();
            n++;
        end
        chk("reset_busy_cycles", n, 4);
        chk("reset_head", head_out, 0);
        chk("reset_left", left_out, 1);
        chk("reset_under", under_out, 0);
        chk("reset_barrier", barrier_out, 0);
        chk("reset_step", step_count, 0);

        run_cmd(1, 0, 0, n, e1, e2);
        chk("adv_busy_cycles", n, 5);
        chk("adv_col", robo_col, 1);
        chk("adv_row", robo_row, 0);
        chk("adv_step", step_count, 1);

        run_cmd(0, 1, 0, n, e1, e2);
        chk("rot1_ori", robo_orientacao, 2);
        run_cmd(0, 1, 0, n, e1, e2);
        chk("rot2_ori", robo_orientacao, 3);
        run_cmd(0, 1, 0, n, e1, e2);
        chk("rot3_ori", robo_orientacao, 0);
        chk("north_head", head_out, 1);
        chk("north_left", left_out, 0);
        run_cmd(1, 0, 0, n, e1, e2);
        chk("bump_busy_cycles", n, 5);
        chk("bump_row", robo_row, 0);
        chk("bump_col", robo_col, 1);
        chk("bump_count", bump_count, 1);
        chk("bump_step", step_count, 1);
        run_cmd(0, 1, 0, n, e1, e2);
        chk("rot4_ori", robo_orientacao, 1);
        chk("east_head", head_out, 0);

        map_write(2, 2'b10, n);
        chk("mapw_busy_cycles", n, 4);
        chk("barrier_seen", barrier_out, 1);
        chk("barrier_head", head_out, 1);

        run_cmd(0, 0, 1, n, e1, e2);
        chk("rem_ok_err", e1, 0);
        chk("rem_ok_barrier", barrier_out, 0);
        chk("rem_ok_head", head_out, 0);

        run_cmd(0, 0, 1, n, e1, e2);
        chk("rem_bad_err", e1, 1);
        chk("rem_bad_err_next", e2, 0);
        chk("rem_bad_barrier", barrier_out, 0);
        chk("rem_bad_head", head_out, 0);

        map_write(3, 2'b11, n);
        run_cmd(1, 1, 0, n, e1, e2);
        chk("advrot_col", robo_col, 2);
        chk("advrot_ori", robo_orientacao, 1);
        chk("advrot_step", step_count, 2);
        chk("marker_ahead_head", head_out, 0);
        chk("marker_ahead_under", under_out, 0);
        run_cmd(1, 0, 0, n, e1, e2);
        chk("marker_col", robo_col, 3);
        chk("marker_step", step_count, 3);
        chk("marker_under", under_out, 1);
        chk("marker_left", left_out, 1);

        // girar, then reset while in SENSE_L
        girar = 1'b1;
        tick();
        girar = 1'b0;
        tick();
        tick();
        chk("pre_abort_busy", busy, 1);
        chk("pre_abort_ori", robo_orientacao, 2);
        rst_n = 1'b0;
        #1;
        chk("abort_row", robo_row, 0);
        chk("abort_col", robo_col, 0);
        chk("abort_ori", robo_orientacao, 1);
        chk("abort_under", under_out, 0);
        chk("abort_step", step_count, 0);
        chk("abort_bump", bump_count, 0);
        chk("abort_busy", busy, 1);
        tick();
        rst_n = 1'b1;
        n = 0;
        while (busy && n < 40) begin
            tick();
            n++;
        end
        chk("abort_busy_cycles", n, 4);
        chk("abort_head", head_out, 0);
        chk("abort_left", left_out, 1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
